// File: rtl/sqd_frame_ctrl.sv
// sqd_frame_ctrl
//   Frame controller for a serial, enable-qualified, non-overlapping Moore
//   1010 detector. Words arrive on a valid/ready handshake, are serialized
//   MSB-first into the detector, and the detector matches seen over a frame
//   are counted (saturating) and reported on a result handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. valid, once raised, is not required to be held by this
//   block's logic; ready depends on registered state only.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   word stream in (bit DATA_W-1 first)
//   det_rst_n        registered active-low reset to the detector
//   det_x, det_en    serial bit and its qualifier to the detector
//   det_z            detector Moore output (1 in its match state)
//   res_valid/res_ready/res_count/res_sat   per-frame result out
module sqd_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              det_rst_n,
  output logic              det_x,
  output logic              det_en,
  input  logic              det_z,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  input  logic              res_ready
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               frame_active_q, frame_active_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic               det_rst_n_q;
  logic               accept;
  logic               inc;

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == S_IDLE) ||
                ((state_q == S_SHIFT) && (bit_idx_q == LAST_IDX) && !last_q);
    det_en    = (state_q == S_SHIFT);
    det_x     = det_en & shift_q[DATA_W-1];
    res_valid = (state_q == S_REPORT);
    accept    = in_valid & in_ready;
  end

  assign det_rst_n = det_rst_n_q;
  assign res_count = count_q;
  assign res_sat   = sat_q;

  always_comb begin
    state_d        = state_q;
    frame_active_d = frame_active_q;
    shift_d        = shift_q;
    bit_idx_d      = bit_idx_q;
    last_d         = last_q;
    count_d        = count_q;
    sat_d          = sat_q;
    inc            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = in_data;
          last_d    = in_last;
          bit_idx_d = '0;
          if (!frame_active_q) begin
            state_d        = S_CLEAR;
            frame_active_d = 1'b1;
            count_d        = '0;
            sat_d          = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_CLEAR: state_d = S_SHIFT;
      S_SHIFT: begin
        // det_z here reflects the match completed by the previous enabled bit.
        inc       = det_z;
        shift_d   = shift_q << 1;
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == LAST_IDX) begin
          if (last_q) begin
            state_d = S_DRAIN;
          end else if (accept) begin
            shift_d   = in_data;
            last_d    = in_last;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // Picks up a match completed by the final bit of the frame.
        inc     = det_z;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d        = S_IDLE;
          frame_active_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (inc) begin
      if (count_q == CNT_MAX) sat_d = 1'b1;
      else                    count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      frame_active_q <= 1'b0;
      shift_q        <= '0;
      bit_idx_q      <= '0;
      last_q         <= 1'b0;
      count_q        <= '0;
      sat_q          <= 1'b0;
      det_rst_n_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_active_q <= frame_active_d;
      shift_q        <= shift_d;
      bit_idx_q      <= bit_idx_d;
      last_q         <= last_d;
      count_q        <= count_d;
      sat_q          <= sat_d;
      // Registered so the detector sees reset exactly during CLEAR.
      det_rst_n_q    <= (state_d != S_CLEAR);
    end
  end

endmodule

// File: tb/tb_sqd_frame_ctrl.sv
// Bench for sqd_frame_ctrl: a behavioural 1010 detector closes the loop,
// and each frame's expected result is computed from its bit string.
module tb_sqd_frame_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              det_rst_n, det_x, det_en;
  logic              det_z;
  logic              res_valid;
  logic [CNT_W-1:0]  res_count;
  logic              res_sat;
  logic              res_ready = 1'b1;

  sqd_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .det_rst_n(det_rst_n), .det_x(det_x), .det_en(det_en), .det_z(det_z),
    .res_valid(res_valid), .res_count(res_count), .res_sat(res_sat),
    .res_ready(res_ready)
  );

  // Non-overlapping Moore 1010 detector, enable-qualified, sync reset.
  int det_s = 0;
  always @(posedge clk) begin
    if (!det_rst_n) det_s <= 0;
    else if (det_en) begin
      case (det_s)
        0: det_s <= det_x ? 1 : 0;
        1: det_s <= det_x ? 1 : 2;
        2: det_s <= det_x ? 3 : 0;
        3: det_s <= det_x ? 1 : 4;
        default: det_s <= det_x ? 1 : 0;
      endcase
    end
  end
  assign det_z = (det_s == 4);

  // scoreboard
  int checks = 0;
  int errors = 0;
  int res_n  = 0;
  logic [CNT_W:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // res_ready driver: updated just after posedge so negedge sampling is race-free.
  logic rand_rr = 1'b0;
  logic rr_force = 1'b1;
  initial forever begin
    @(posedge clk); #1;
    res_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_force;
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (!det_en) chk("det_x_when_disabled", {31'b0, det_x}, 32'd0);
      if (res_valid && res_ready) begin
        res_n++;
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          logic [CNT_W:0] e;
          e = exp_q.pop_front();
          chk("res_count", {30'b0, res_count}, {30'b0, e[CNT_W-1:0]});
          chk("res_sat", {31'b0, res_sat}, {31'b0, e[CNT_W]});
        end
      end
    end
  end

  // reference model: greedy non-overlapping count of 1010 over the frame bits
  logic [DATA_W-1:0] fw[8];
  task automatic push_expected(input int nw);
    bit b[$];
    int i, m;
    logic [CNT_W:0] e;
    for (int w = 0; w < nw; w++)
      for (int k = DATA_W - 1; k >= 0; k--) b.push_back(fw[w][k]);
    m = 0; i = 0;
    while (i + 3 < b.size()) begin
      if (b[i] && !b[i+1] && b[i+2] && !b[i+3]) begin m++; i += 4; end
      else i++;
    end
    e[CNT_W]       = (m > (2**CNT_W - 1));
    e[CNT_W-1:0]   = (m > (2**CNT_W - 1)) ? CNT_W'(2**CNT_W - 1) : CNT_W'(m);
    exp_q.push_back(e);
  endtask

  // driver: returns on the negedge just after the accepting posedge
  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("in_ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int nw, input int maxgap);
    push_expected(nw);
    for (int i = 0; i < nw; i++)
      send_word(fw[i], (i == nw - 1), $urandom_range(0, maxgap));
  endtask

  task automatic wait_res_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [CNT_W-1:0] held;
    int rn;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_det_rst_n", {31'b0, det_rst_n}, 32'd0);
    chk("rst_det_en", {31'b0, det_en}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_count", {30'b0, res_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("det_rst_n_release", {31'b0, det_rst_n}, 32'd1);

    // single 0xAA, timing
    fw[0] = 8'hAA; push_expected(1);
    send_word(8'hAA, 1'b1, 0);
    chk("clear_det_rst_n", {31'b0, det_rst_n}, 32'd0);
    chk("clear_in_ready", {31'b0, in_ready}, 32'd0);
    cyc = 1;
    while (!res_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("res_valid_cycle", cyc, 32'd11);
    @(negedge clk);
    chk("res_valid_one_cycle", {31'b0, res_valid}, 32'd0);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // 0xA5
    fw[0] = 8'hA5; run_frame(1, 0);
    wait_res_valid("a5_timeout");
    repeat (2) @(negedge clk);

    // 0x01, gap, 0x40: match spans the boundary
    fw[0] = 8'h01; fw[1] = 8'h40; push_expected(2);
    send_word(8'h01, 1'b0, 0);
    repeat (9) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("gap_det_en", {31'b0, det_en}, 32'd0);
      chk("gap_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
    end
    send_word(8'h40, 1'b1, 0);
    wait_res_valid("gap_timeout");
    repeat (2) @(negedge clk);

    // saturation then clear
    fw[0] = 8'hAA; fw[1] = 8'hAA; fw[2] = 8'hAA; run_frame(3, 0);
    fw[0] = 8'h00; run_frame(1, 0);
    wait_res_valid("sat_clear_timeout");
    repeat (2) @(negedge clk);

    // result stall
    rr_force = 1'b0;
    @(negedge clk);
    rn = res_n;
    fw[0] = 8'hAA; run_frame(1, 0);
    wait_res_valid("stall_timeout");
    held = res_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_count", {30'b0, res_count}, {30'b0, held});
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
    end
    rr_force = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_one_result", res_n - rn, 32'd1);

    // reset during 4th bit
    rn = res_n;
    send_word(8'hAA, 1'b1, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_det_rst_n", {31'b0, det_rst_n}, 32'd0);
    chk("mid_rst_det_en", {31'b0, det_en}, 32'd0);
    chk("mid_rst_det_x", {31'b0, det_x}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_rst_res_count", {30'b0, res_count}, 32'd0);
    chk("mid_rst_res_sat", {31'b0, res_sat}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_result", res_n - rn, 32'd0);
    fw[0] = 8'hAA; run_frame(1, 0);
    wait_res_valid("post_rst_timeout");
    repeat (2) @(negedge clk);

    // randomized frames with random result backpressure
    rand_rr = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++)
        fw[i] = ($urandom_range(0, 3) == 0) ? 8'hAA : DATA_W'($urandom);
      run_frame(nw, 3);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
